// File: rtl/router_event_monitor.sv
// Per-router traffic statistics: saturating per-port event counters sampled over a
// programmable window, copied into a snapshot bank read through a registered port.
module router_event_monitor #(
   parameter int P     = 5,
   parameter int CNT_W = 32,
   parameter int WIN_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [P-1:0]         ev_flit_wr_i,
   input  logic [P-1:0]         ev_pck_wr_i,
   input  logic [P-1:0]         ev_flit_wr_o,
   input  logic [P-1:0]         ev_pck_wr_o,
   input  logic [P-1:0]         ev_bypassed,
   input  logic [P-1:0]         ev_empty,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 cont_mode,
   input  logic [WIN_W-1:0]     window_len,
   input  logic                 rd_en,
   input  logic [$clog2(P)-1:0] rd_port,
   input  logic [2:0]           rd_sel,
   output logic [CNT_W-1:0]     rd_data,
   output logic                 rd_valid,
   output logic                 snap_valid,
   output logic                 busy
);

   localparam int NSEL = 6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIN_W-1:0] win_cnt;
   logic [P-1:0]     ev   [NSEL];
   logic [CNT_W-1:0] live [NSEL][P];
   logic [CNT_W-1:0] nxt  [NSEL][P];
   logic [CNT_W-1:0] snap [NSEL][P];

   always_comb begin
      ev[0] = ev_flit_wr_i;
      ev[1] = ev_pck_wr_i;
      ev[2] = ev_flit_wr_o;
      ev[3] = ev_pck_wr_o;
      ev[4] = ev_bypassed;
      ev[5] = ~ev_empty;
   end

   // Saturating increment: a counter at all-ones holds its value
   always_comb begin
      for (int unsigned s = 0; s < NSEL; s++) begin
         for (int unsigned k = 0; k < P; k++) begin
            nxt[s][k] = live[s][k];
            if (ev[s][k] && (live[s][k] != '1))
               nxt[s][k] = live[s][k] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         win_cnt    <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         snap_valid <= 1'b0;
         busy       <= 1'b0;
         for (int unsigned s = 0; s < NSEL; s++) begin
            for (int unsigned k = 0; k < P; k++) begin
               live[s][k] <= '0;
               snap[s][k] <= '0;
            end
         end
      end else begin
         snap_valid <= 1'b0;
         rd_valid   <= rd_en;
         if (rd_en) begin
            if ((rd_sel <= 3'd5) && (int'(rd_port) < P))
               rd_data <= snap[rd_sel][rd_port];
            else
               rd_data <= '0;
         end

         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  win_cnt <= window_len;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  for (int unsigned s = 0; s < NSEL; s++)
                     for (int unsigned k = 0; k < P; k++)
                        live[s][k] <= '0;
               end else if (win_cnt == WIN_W'(1)) begin
                  // Window end: snapshot includes this cycle's events
                  snap_valid <= 1'b1;
                  for (int unsigned s = 0; s < NSEL; s++) begin
                     for (int unsigned k = 0; k < P; k++) begin
                        snap[s][k] <= nxt[s][k];
                        live[s][k] <= '0;
                     end
                  end
                  if (cont_mode) begin
                     win_cnt <= window_len;
                  end else begin
                     win_cnt <= win_cnt - 1'b1;
                     state   <= IDLE;
                     busy    <= 1'b0;
                  end
               end else begin
                  win_cnt <= win_cnt - 1'b1;
                  live    <= nxt;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
